// File: rtl/calc_if.sv
// calc_if: switch/button inputs, external adder connection and FND outputs of calc_sequencer.
interface calc_if;
    logic [7:0] sw;
    logic       btn_step;
    logic       btn_clr;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [7:0] add_s;
    logic       add_cout;
    logic [7:0] seg;
    logic [3:0] seg_common;
    logic       c_led;
    modport slave (
        input  sw, btn_step, btn_clr, add_s, add_cout,
        output add_a, add_b, seg, seg_common, c_led
    );
    modport master (
        output sw, btn_step, btn_clr, add_s, add_cout,
        input  add_a, add_b, seg, seg_common, c_led
    );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: latches two switch operands for an external adder and scans operand/sum onto a 4-digit FND.
// Defining CALC_DEBOUNCE_EN inserts a per-button debounce filter ahead of the edge detect.
module calc_sequencer #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic  clk,
    input  logic  reset,
    calc_if.slave bus
);
    typedef enum logic [1:0] {LOAD_A, LOAD_B, ADD, SHOW} state_t;
    localparam int SW = $clog2(SCAN_DIV);

    if (SCAN_DIV < 4 || DEBOUNCE_CYC < 2) begin : g_bad_param
        $error("calc_sequencer: SCAN_DIV must be >= 4 and DEBOUNCE_CYC >= 2");
    end

    logic [1:0] r_step_sync, r_clr_sync, r_lvl_d;
    logic [1:0] w_raw, w_lvl;
    logic       w_step_p, w_clr_p;

    assign w_raw = {r_clr_sync[1], r_step_sync[1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_sync <= '0;
            r_clr_sync  <= '0;
            r_lvl_d     <= '0;
        end else begin
            r_step_sync <= {r_step_sync[0], bus.btn_step};
            r_clr_sync  <= {r_clr_sync[0], bus.btn_clr};
            r_lvl_d     <= w_lvl;
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYC);
    logic [1:0][DW-1:0] r_db_cnt;
    logic [1:0]         r_db_lvl;

    // Filtered level flips on the DEBOUNCE_CYC-th consecutive cycle of disagreement.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                r_db_lvl[i] <= 1'b0;
                r_db_cnt[i] <= '0;
            end else if (w_raw[i] == r_db_lvl[i]) begin
                r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
                r_db_lvl[i] <= w_raw[i];
                r_db_cnt[i] <= '0;
            end else begin
                r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
        end
    end

    assign w_lvl = r_db_lvl;
`else
    assign w_lvl = w_raw;
`endif

    assign w_step_p = w_lvl[0] & ~r_lvl_d[0];
    assign w_clr_p  = w_lvl[1] & ~r_lvl_d[1];

    state_t r_state, w_next;
    logic   w_ld_a, w_ld_b, w_ld_r;

    always_ff @(posedge clk) begin
        if (reset) r_state <= LOAD_A;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_ld_a = 1'b0;
        w_ld_b = 1'b0;
        w_ld_r = 1'b0;
        if (w_clr_p) w_next = LOAD_A;
        else begin
            case (r_state)
                LOAD_A: if (w_step_p) begin w_next = LOAD_B; w_ld_a = 1'b1; end
                LOAD_B: if (w_step_p) begin w_next = ADD; w_ld_b = 1'b1; end
                ADD:    begin w_next = SHOW; w_ld_r = 1'b1; end
                SHOW:   if (w_step_p) w_next = LOAD_A;
                default: w_next = LOAD_A;
            endcase
        end
    end

    logic [8:0] r_result;

    always_ff @(posedge clk) begin
        if (reset || w_clr_p) begin
            bus.add_a <= '0;
            bus.add_b <= '0;
            r_result  <= '0;
            bus.c_led <= 1'b0;
        end else begin
            if (w_ld_a) bus.add_a <= bus.sw;
            if (w_ld_b) bus.add_b <= bus.sw;
            if (w_ld_r) begin
                r_result  <= {bus.add_cout, bus.add_s};
                bus.c_led <= bus.add_cout;
            end
        end
    end

    function automatic logic [7:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    logic [8:0]    w_val;
    logic [3:0]    w_ones, w_tens, w_hund, w_code, w_sel;
    logic [SW-1:0] r_scan_cnt;
    logic [1:0]    r_dig, w_dig_n;
    logic          r_on, w_on_n, w_tick;

    assign w_val  = (r_state == SHOW || r_state == ADD) ? r_result : {1'b0, bus.sw};
    assign w_ones = 4'(w_val % 10);
    assign w_tens = 4'((w_val / 10) % 10);
    assign w_hund = 4'(w_val / 100);
    assign w_code = (r_state == LOAD_A) ? 4'd1 : (r_state == LOAD_B) ? 4'd2 : 4'd3;

    // Digits stay dark until the first wrap, which lights digit 0 without advancing.
    assign w_tick  = r_scan_cnt == SW'(SCAN_DIV - 1);
    assign w_on_n  = r_on | w_tick;
    assign w_dig_n = r_dig + {1'b0, w_tick & r_on};
    assign w_sel   = (w_dig_n == 2'd0) ? w_ones :
                     (w_dig_n == 2'd1) ? ((w_val < 9'd10) ? 4'hF : w_tens) :
                     (w_dig_n == 2'd2) ? ((w_val < 9'd100) ? 4'hF : w_hund) : w_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt     <= '0;
            r_dig          <= '0;
            r_on           <= 1'b0;
            bus.seg        <= 8'hFF;
            bus.seg_common <= 4'hF;
        end else begin
            r_scan_cnt     <= w_tick ? '0 : r_scan_cnt + 1'b1;
            r_dig          <= w_dig_n;
            r_on           <= w_on_n;
            bus.seg        <= w_on_n ? f_seg(w_sel) : 8'hFF;
            bus.seg_common <= w_on_n ? ~(4'b0001 << w_dig_n) : 4'hF;
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: randomized operand/clear sequences against a step-count model; a monitor
// process pops expected snapshots and compares them with a full scan of the display.
module tb_calc_sequencer;
    localparam int SCAN = 4;
    localparam int DEB  = 8;
    localparam int HOLD = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    calc_if bus();
    calc_sequencer #(.SCAN_DIV(SCAN), .DEBOUNCE_CYC(DEB)) dut (.clk(clk), .reset(reset), .bus(bus));
    assign {bus.add_cout, bus.add_s} = bus.add_a + bus.add_b;

    typedef struct packed {
        logic [7:0]      a;
        logic [7:0]      b;
        logic            c;
        logic [3:0][7:0] d;
    } snap_t;

    snap_t exp_q[$];
    int checks = 0, errors = 0, pushed = 0, done = 0;
    int m_a = 0, m_b = 0, m_res = 0, m_c = 0, m_ph = 0;
    logic [7:0] tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic chk(string n, logic [8:0] got, logic [8:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, want);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: phase 0/1/2 = waiting for A / waiting for B / showing the sum.
    function automatic void m_step();
        if (m_ph == 0) begin m_a = int'(bus.sw); m_ph = 1; end
        else if (m_ph == 1) begin
            m_b = int'(bus.sw);
            m_res = m_a + m_b;
            m_c = m_res / 256;
            m_ph = 2;
        end else m_ph = 0;
    endfunction

    function automatic void m_clr();
        m_a = 0; m_b = 0; m_res = 0; m_c = 0; m_ph = 0;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        int v;
        v = (m_ph == 2) ? m_res : int'(bus.sw);
        s.a = 8'(m_a);
        s.b = 8'(m_b);
        s.c = (m_c != 0);
        s.d[0] = tab[v % 10];
        s.d[1] = (v < 10) ? 8'hFF : tab[(v / 10) % 10];
        s.d[2] = (v < 100) ? 8'hFF : tab[v / 100];
        s.d[3] = tab[m_ph + 1];
        return s;
    endfunction

    task automatic snap();
        exp_q.push_back(model_snap());
        pushed++;
        for (int t = 0; t < 200 && done != pushed; t++) @(negedge clk);
        if (done != pushed) begin
            checks++; errors++;
            $display("FAIL monitor_timeout: done %0d expected %0d", done, pushed);
            done = pushed;
        end
    endtask

    task automatic press(logic s, logic c, int hold);
        bus.btn_step = s;
        bus.btn_clr  = c;
        cyc(hold);
        bus.btn_step = 1'b0;
        bus.btn_clr  = 1'b0;
        cyc(20);
    endtask

    // Holds step until add_b changes, returning at the negedge right after the latch edge.
    task automatic step_watch();
        logic [7:0] pb;
        logic seen;
        pb = bus.add_b;
        seen = 1'b0;
        bus.btn_step = 1'b1;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (t == HOLD - 1) bus.btn_step = 1'b0;
            seen = (bus.add_b != pb);
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL latch_b_timeout: add_b stayed %0h", bus.add_b);
        end
    endtask

    initial begin : monitor
        snap_t e;
        logic [7:0] got [4];
        logic [3:0] seen, m;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("add_a", {1'b0, bus.add_a}, {1'b0, e.a});
                chk("add_b", {1'b0, bus.add_b}, {1'b0, e.b});
                chk("c_led", {8'h0, bus.c_led}, {8'h0, e.c});
                seen = '0;
                for (int t = 0; t < 64 && seen != 4'hF; t++) begin
                    @(negedge clk);
                    for (int i = 0; i < 4; i++) begin
                        m = 4'b0001 << i;
                        if (bus.seg_common == ~m) begin got[i] = bus.seg; seen[i] = 1'b1; end
                    end
                end
                chk("scan_all_digits", {5'h0, seen}, 9'hF);
                for (int i = 0; i < 4; i++) chk($sformatf("digit%0d", i), {1'b0, got[i]}, {1'b0, e.d[i]});
                done++;
            end
        end
    end

    initial begin : stim
        bus.sw = 8'd0;
        bus.btn_step = 1'b0;
        bus.btn_clr = 1'b0;
        cyc(3);
        chk("rst_add_a", {1'b0, bus.add_a}, 9'h0);
        chk("rst_add_b", {1'b0, bus.add_b}, 9'h0);
        chk("rst_c_led", {8'h0, bus.c_led}, 9'h0);
        chk("rst_seg", {1'b0, bus.seg}, 9'hFF);
        chk("rst_common", {5'h0, bus.seg_common}, 9'hF);
        reset = 1'b0;
        cyc(3);
        chk("scan_dark", {5'h0, bus.seg_common}, 9'hF);
        cyc(1);
        chk("scan_first", {5'h0, bus.seg_common}, 9'hE);

        bus.sw = 8'd200;
        press(1'b1, 1'b0, HOLD);
        m_step();
        bus.sw = 8'd100;
        step_watch();
        chk("cled_before_add", {8'h0, bus.c_led}, 9'h0);
        cyc(1);
        chk("cled_after_add", {8'h0, bus.c_led}, 9'h1);
        bus.btn_step = 1'b0;
        cyc(20);
        m_step();
        chk("carry_a", {1'b0, bus.add_a}, 9'd200);
        chk("carry_b", {1'b0, bus.add_b}, 9'd100);
        snap();

        bus.sw = 8'($urandom);
        press(1'b1, 1'b0, HOLD);
        m_step();
        snap();

        bus.sw = 8'd5;
        press(1'b1, 1'b0, HOLD);
        m_step();
        bus.sw = 8'd2;
        press(1'b1, 1'b0, HOLD);
        m_step();
        chk("blank_c_led", {8'h0, bus.c_led}, 9'h0);
        snap();

        press(1'b1, 1'b1, HOLD);
        m_clr();
        snap();

        bus.sw = 8'($urandom);
        press(1'b1, 1'b0, 50);
        m_step();
        snap();

`ifdef CALC_DEBOUNCE_EN
        press(1'b1, 1'b0, 5);
        snap();
`endif

        press(1'b0, 1'b1, HOLD);
        m_clr();
        bus.sw = 8'd200;
        press(1'b1, 1'b0, HOLD);
        m_step();
        bus.sw = 8'd100;
        step_watch();
        reset = 1'b1;
        bus.btn_step = 1'b0;
        cyc(1);
        chk("midrst_c_led", {8'h0, bus.c_led}, 9'h0);
        chk("midrst_add_a", {1'b0, bus.add_a}, 9'h0);
        chk("midrst_seg", {1'b0, bus.seg}, 9'hFF);
        chk("midrst_common", {5'h0, bus.seg_common}, 9'hF);
        reset = 1'b0;
        m_clr();
        cyc(2);
        snap();

        for (int k = 0; k < 30; k++) begin
            bus.sw = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                press(1'b0, 1'b1, HOLD);
                m_clr();
            end else begin
                press(1'b1, 1'b0, HOLD);
                m_step();
            end
            snap();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
